// File: rtl/multimem_pkg.sv
// Shared types and helpers for the ping-pong frame memory: clear FSM states,
// lane index mapping and address-width derivations.
package multimem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int lane_bits(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int rd_aw(input int rd_depth);
        return $clog2(rd_depth);
    endfunction

    function automatic int wr_aw(input int rd_depth, input int ratio);
        return $clog2(rd_depth) + $clog2(ratio);
    endfunction

    // With reversal the lowest narrow address lands in the most significant lane.
    function automatic int lane_idx(input int low, input int ratio, input bit rev);
        return rev ? (ratio - 1 - low) : low;
    endfunction

endpackage

// File: rtl/multimem_pingpong_lane_ram.sv
// One lane of storage: both banks live in a single simple dual-port RAM,
// addressed as {bank, word}, with a registered synchronous read port.
module lane_ram #(
    parameter  int W     = 8,
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2*DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Output register holds the last read word while re_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multimem_pingpong.sv
// Double-buffered frame memory: narrow writes into the back bank, wide reads
// from the front bank, frame-synchronous swap and a back-bank clear sequencer.
module multimem_pingpong
    import multimem_pkg::*;
#(
    parameter  int                  WR_WIDTH     = 8,
    parameter  int                  RATIO        = 2,
    parameter  int                  RD_DEPTH     = 2048,
    parameter  int                  LANE_REVERSE = 1,
    parameter  logic [WR_WIDTH-1:0] CLEAR_VALUE  = '0,
    localparam int                  LW           = lane_bits(RATIO),
    localparam int                  RD_AW        = rd_aw(RD_DEPTH),
    localparam int                  WR_AW        = wr_aw(RD_DEPTH, RATIO),
    localparam int                  RD_WIDTH     = WR_WIDTH * RATIO
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic [WR_WIDTH-1:0] DataIn,
    input  logic [WR_AW-1:0]    Address,
    input  logic                Wr,
    input  logic [RD_AW-1:0]    AddressB,
    input  logic                RdEn,
    output logic [RD_WIDTH-1:0] QB,
    output logic                QBValid,
    input  logic                FrameDone,
    input  logic                SwapReq,
    output logic                SwapAck,
    input  logic                ClearReq,
    output logic                Busy,
    output logic                WrDropped,
    output logic                FrontBank
);

    state_e             state_q, state_d;
    logic [RD_AW-1:0]   cnt_q, cnt_d;
    logic               front_q, front_d;
    logic               pend_q, pend_d;
    logic               ack_q, drop_q, qbv_q;
    logic               busy, clr_we, wr_ok, wr_drop, swap_fire;
    logic [LW-1:0]      lane_sel;
    logic [RD_AW-1:0]   wword;
    logic [WR_WIDTH-1:0] wdata;
    logic [RD_AW:0]     waddr, raddr;
    logic [RATIO-1:0]   lane_we;
    logic [RATIO-1:0][WR_WIDTH-1:0] rd_lanes;

    // ---- clear FSM: state register ----
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- clear FSM: next state ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RD_AW'(RD_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- clear FSM: outputs ----
    always_comb begin
        busy    = 1'b0;
        clr_we  = 1'b0;
        wr_ok   = 1'b0;
        wr_drop = 1'b0;
        case (state_q)
            ST_IDLE: wr_ok = Wr;
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                wr_drop = Wr;
            end
            default: ;
        endcase
    end

    // Swap may fire in the very cycle SwapReq arrives; pending is only the memory.
    always_comb begin
        swap_fire = (pend_q | SwapReq) & FrameDone & (state_q == ST_IDLE);
        pend_d    = swap_fire ? 1'b0 : (pend_q | SwapReq);
        front_d   = swap_fire ? ~front_q : front_q;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
            qbv_q   <= 1'b0;
        end else begin
            front_q <= front_d;
            pend_q  <= pend_d;
            ack_q   <= swap_fire;
            drop_q  <= wr_drop;
            qbv_q   <= RdEn;
        end
    end

    // Write path always uses the current (pre-swap) back bank.
    always_comb begin
        lane_sel = LW'(lane_idx(int'(Address[LW-1:0]), RATIO, LANE_REVERSE != 0));
        wword    = clr_we ? cnt_q : Address[WR_AW-1:LW];
        wdata    = clr_we ? CLEAR_VALUE : DataIn;
        waddr    = {~front_q, wword};
        raddr    = {front_q, AddressB};
    end

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign lane_we[i] = clr_we | (wr_ok & (lane_sel == LW'(i)));

        lane_ram #(
            .W     (WR_WIDTH),
            .DEPTH (RD_DEPTH)
        ) u_ram (
            .clk_i   (Clock),
            .rst_ni  (ResetN),
            .we_i    (lane_we[i]),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (RdEn),
            .raddr_i (raddr),
            .rdata_o (rd_lanes[i])
        );
    end

    assign QB        = rd_lanes;
    assign QBValid   = qbv_q;
    assign SwapAck   = ack_q;
    assign Busy      = busy;
    assign WrDropped = drop_q;
    assign FrontBank = front_q;

endmodule

// File: tb/tb_multimem_pingpong.sv
// Scoreboard bench for multimem_pingpong at default parameters: read
// expectations come from a per-bank byte model and are checked as QB returns.
module tb_multimem_pingpong;

    localparam int DEPTH = 2048;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b1;
    logic [7:0]  DataIn = '0;
    logic [11:0] Address = '0;
    logic        Wr = 1'b0;
    logic [10:0] AddressB = '0;
    logic        RdEn = 1'b0;
    logic [15:0] QB;
    logic        QBValid;
    logic        FrameDone = 1'b0;
    logic        SwapReq = 1'b0;
    logic        SwapAck;
    logic        ClearReq = 1'b0;
    logic        Busy;
    logic        WrDropped;
    logic        FrontBank;

    multimem_pingpong dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .DataIn    (DataIn),
        .Address   (Address),
        .Wr        (Wr),
        .AddressB  (AddressB),
        .RdEn      (RdEn),
        .QB        (QB),
        .QBValid   (QBValid),
        .FrameDone (FrameDone),
        .SwapReq   (SwapReq),
        .SwapAck   (SwapAck),
        .ClearReq  (ClearReq),
        .Busy      (Busy),
        .WrDropped (WrDropped),
        .FrontBank (FrontBank)
    );

    always #5 Clock = ~Clock;

    int          nchk = 0;
    int          nfail = 0;
    logic [15:0] mdl [2][DEPTH];
    logic        mfront = 1'b0;
    logic [15:0] sbq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Narrow write into the model's back bank; address LSB 0 is the high byte.
    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        int unsigned lane;
        Address = a;
        DataIn  = d;
        Wr      = 1'b1;
        lane    = a[0] ? 0 : 1;
        mdl[~mfront][a[11:1]][lane*8 +: 8] = d;
        tick();
        Wr = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a);
        AddressB = a;
        RdEn     = 1'b1;
        tick();
        RdEn = 1'b0;
    endtask

    always @(posedge Clock) begin
        if (ResetN && RdEn) sbq.push_back(mdl[mfront][AddressB]);
    end

    always @(negedge Clock) begin
        if (ResetN && QBValid) begin
            if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                 chk("qb", QB, sbq.pop_front());
        end
    end

    initial begin
        int n;
        logic any_ack;

        #2 ResetN = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_qb", QB, 0);
        chk("rst_qbvalid", QBValid, 0);
        chk("rst_swapack", SwapAck, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_wrdropped", WrDropped, 0);
        chk("rst_front", FrontBank, 0);
        ResetN = 1'b1;
        tick();

        // lane mapping and a second word into back bank 1
        wr(12'd0, 8'hAA);
        wr(12'd1, 8'h55);
        wr(12'd10, 8'h12);
        wr(12'd11, 8'h34);

        // swap gated by FrameDone
        SwapReq = 1'b1;
        tick();
        SwapReq = 1'b0;
        any_ack = 1'b0;
        repeat (10) begin
            tick();
            any_ack |= SwapAck;
        end
        chk("gate_noack", any_ack, 0);
        chk("gate_front0", FrontBank, 0);
        FrameDone = 1'b1;
        tick();
        FrameDone = 1'b0;
        chk("swap_ack", SwapAck, 1);
        chk("swap_front1", FrontBank, 1);
        mfront = 1'b1;
        tick();
        chk("swap_ack_pulse", SwapAck, 0);

        rd(11'd0);
        rd(11'd5);
        // old front is now the back bank; it must not disturb front word 5
        wr(12'd10, 8'hFF);
        rd(11'd5);
        tick();

        // fill back bank 0 with 0xABCD
        for (int w = 0; w < DEPTH; w++) begin
            wr(12'(2*w), 8'hAB);
            wr(12'(2*w+1), 8'hCD);
        end

        // ClearReq together with Wr in IDLE: the write is accepted
        Address  = 12'd4;
        DataIn   = 8'h11;
        Wr       = 1'b1;
        ClearReq = 1'b1;
        tick();
        Wr = 1'b0;
        ClearReq = 1'b0;
        chk("clr_start_busy", Busy, 1);
        chk("clr_start_nodrop", WrDropped, 0);
        n = 0;
        any_ack = 1'b0;
        while (Busy && n < 3000) begin
            n++;
            any_ack |= SwapAck;
            if (n == 100) begin Address = 12'd6; DataIn = 8'h77; Wr = 1'b1; end
            if (n == 101) begin chk("clr_wrdrop", WrDropped, 1); Wr = 1'b0; end
            if (n == 102) chk("clr_wrdrop_pulse", WrDropped, 0);
            if (n == 200) begin SwapReq = 1'b1; FrameDone = 1'b1; end
            if (n == 201) SwapReq = 1'b0;
            tick();
        end
        chk("clr_busy_len", n, DEPTH);
        chk("clr_swap_deferred", any_ack, 0);
        chk("clr_front_kept", FrontBank, 1);
        for (int w = 0; w < DEPTH; w++) mdl[0][w] = 16'h0000;
        tick();
        chk("defer_ack", SwapAck, 1);
        chk("defer_front0", FrontBank, 0);
        FrameDone = 1'b0;
        mfront = 1'b0;
        tick();

        // whole cleared bank reads zero
        RdEn = 1'b1;
        for (int w = 0; w < DEPTH; w++) begin
            AddressB = 11'(w);
            tick();
        end
        RdEn = 1'b0;
        tick();

        // reset mid-clear, with front=1, a read stream and a pending swap
        SwapReq = 1'b1;
        FrameDone = 1'b1;
        tick();
        SwapReq = 1'b0;
        FrameDone = 1'b0;
        chk("swap2_front1", FrontBank, 1);
        mfront = 1'b1;
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        AddressB = 11'd0;
        RdEn = 1'b1;
        repeat (50) tick();
        chk("mid_busy", Busy, 1);
        SwapReq = 1'b1;
        tick();
        SwapReq = 1'b0;
        tick();
        chk("mid_qbvalid", QBValid, 1);
        #1 ResetN = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_swapack", SwapAck, 0);
        chk("arst_qbvalid", QBValid, 0);
        chk("arst_front", FrontBank, 0);
        chk("arst_qb", QB, 0);
        RdEn = 1'b0;
        mfront = 1'b0;
        sbq.delete();
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        FrameDone = 1'b1;
        any_ack = 1'b0;
        repeat (5) begin
            tick();
            any_ack |= SwapAck;
        end
        FrameDone = 1'b0;
        chk("pend_lost_noack", any_ack, 0);
        chk("pend_lost_front", FrontBank, 0);
        rd(11'd0);
        rd(11'd5);
        tick();
        chk("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/multimem_pingpong.md
Name: multimem_pingpong

Overview:
- Parametrised successor to the panel frame memory: narrow write port, wide read port, lane-interleaved storage.
- Adds two banks (front/back) with a frame-synchronous swap handshake, plus a hardware clear sequencer for the back bank.
- Sits between the frame-data writer (UART/command path) and the row scanner that reads wide pixel words.
- Single clock domain.

Parameters:
- WR_WIDTH, 8, write data width in bits (one lane).
- RATIO, 2, lanes per read word; RD_WIDTH = WR_WIDTH*RATIO. Must be a power of 2, ≥2.
- RD_DEPTH, 2048, read words per bank; RD_AW = clog2(RD_DEPTH).
- WR_AW, derived = RD_AW + clog2(RATIO), write address width.
- LANE_REVERSE, 1. When 1, lane index = RATIO-1-Address[low]; the highest narrow address lands in QB[WR_WIDTH-1:0].
- CLEAR_VALUE, 0, WR_WIDTH-bit value written to every lane during clear.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- ResetN  in  1  asynchronous reset, active low.
- DataIn  in  WR_WIDTH  write data.
- Address  in  WR_AW  write address in the back bank.
- Wr  in  1  write strobe.
- AddressB  in  RD_AW  read word address in the front bank.
- RdEn  in  1  read strobe.
- QB  out  RD_WIDTH  read data.
- QBValid  out  1  QB updated this cycle.
- FrameDone  in  1  scanner at frame boundary; swap window.
- SwapReq  in  1  pulse: request a front/back exchange.
- SwapAck  out  1  one-cycle pulse when the swap executes.
- ClearReq  in  1  pulse: clear the back bank.
- Busy  out  1  clear in progress.
- WrDropped  out  1  one-cycle pulse: a Wr was ignored.
- FrontBank  out  1  index of the current front bank.

Behaviour:
- Reset values: QB=0, QBValid=0, SwapAck=0, Busy=0, WrDropped=0, FrontBank=0, swap_pending=0, FSM=IDLE. RAM contents are not reset.
- Write: lane = Address[clog2(RATIO)-1:0], mapped through LANE_REVERSE. Word = Address[WR_AW-1:clog2(RATIO)]. Only that lane of that word in bank ~FrontBank is written. Other lanes are untouched.
- Read: RdEn at cycle N produces QB and QBValid=1 at N+1 from the front bank sampled at N. QB holds its value when RdEn=0.
- Read-during-write: cannot collide, because writes always target the back bank.
- Swap:
  - SwapReq sets swap_pending. Extra requests while pending are merged.
  - Swap executes on the first cycle where swap_pending=1, FrameDone=1 and FSM=IDLE. This includes the same cycle as SwapReq.
  - On execution: FrontBank toggles at the next edge, SwapAck=1 for one cycle, swap_pending cleared.
  - Reads and writes issued in the swap cycle use the pre-swap bank mapping.
- Clear FSM:
  - IDLE: ClearReq → CLEAR with cnt=0 and Busy=1. ClearReq while in CLEAR is ignored.
  - CLEAR: each cycle writes CLEAR_VALUE to all lanes of word cnt in the back bank, then cnt++. At cnt=RD_DEPTH-1, write and return to IDLE; Busy drops on the following edge. Duration is exactly RD_DEPTH cycles.
  - During CLEAR: Wr is ignored and WrDropped pulses. Swap is deferred and stays pending. Reads are unaffected.
  - Simultaneous ClearReq and Wr in IDLE: the write is performed and the clear starts next cycle.
- Reset mid-clear or mid-pending: returns to IDLE, pending is lost, FrontBank=0, and partially cleared content remains.

Decomposition:
- Shared package multimem_pkg holds: FSM state enum (IDLE, CLEAR), lane-index function (with reversal), and clog2 derivations.
- Sub-module lane_ram: one WR_WIDTH × (2*RD_DEPTH) simple dual-port RAM with synchronous read, address {bank, word}. It is instantiated RATIO times.
- Top module holds: lane decode, swap logic, clear counter/FSM, output registers.

Test Plan:
- Lane mapping: defaults; Wr Address=0 Data=0xAA, Address=1 Data=0x55; SwapReq+FrameDone; RdEn AddressB=0 → next cycle QB=0xAA55, QBValid=1.
- Swap gating: SwapReq with FrameDone=0 for 10 cycles → no SwapAck, FrontBank=0. FrameDone=1 → SwapAck one cycle, FrontBank=1. Old front (bank 0) is now writable.
- Back-bank isolation: front word 5 holds 0x1234; write 0xFF at Address 10 (back) → read AddressB=5 still returns 0x1234.
- Clear: back filled with 0xABCD, ClearReq → Busy high exactly 2048 cycles, Wr during clear → WrDropped pulses. After swap, every word reads 0x0000.
- Deferred swap: SwapReq+FrameDone during CLEAR → no SwapAck until Busy falls. Then SwapAck on the first cycle with FrameDone=1.
- Async reset: assert ResetN=0 mid-clear with FrontBank=1 → Busy, SwapAck, QBValid, FrontBank all 0 immediately.
